// File: rtl/maxpool2x2_seq_pkg.sv
// ============================================================================
//  Module      : maxpool2x2_seq_pkg
//  Description : Shared definitions for the POOL blocks.
//                - pool_state_e : frame sequencer state encoding
//                - lb_addr_w()  : line-buffer address width for a max width
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package maxpool2x2_seq_pkg;

    // ROW_A consumes even rows (fills the line buffer), ROW_B consumes odd
    // rows (combines with the buffered row and emits pooled pixels).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROW_A = 2'd1,
        ST_ROW_B = 2'd2,
        ST_DONE  = 2'd3
    } pool_state_e;

    // One line-buffer entry holds the horizontal max of a pixel pair, so
    // the depth is max_w/2. A depth of 1 still needs a 1-bit address.
    function automatic int lb_addr_w(input int max_w);
        int depth;
        depth = max_w / 2;
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int LB_AW_DEFAULT = lb_addr_w(64);

endpackage : maxpool2x2_seq_pkg

`default_nettype wire

// File: rtl/pool_cmp.sv
// ============================================================================
//  Module      : pool_cmp
//  Description : Combinational unsigned maximum of two DW-bit operands.
//  Ports       : a_i, b_i  - operands
//                max_o     - larger of the two (a_i when equal)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_cmp #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] max_o
);

    assign max_o = (b_i > a_i) ? b_i : a_i;

endmodule : pool_cmp

`default_nettype wire

// File: rtl/pool_linebuf.sv
// ============================================================================
//  Module      : pool_linebuf
//  Description : MAX_W/2 x DW line buffer, one synchronous write port and one
//                combinational read port. Contents are not reset; the
//                sequencer always writes an entry during an even row before
//                the following odd row reads it.
//  Ports       : clk              - clock
//                we_i/waddr_i/wdata_i - write port
//                raddr_i/rdata_o  - asynchronous read port
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_linebuf #(
    parameter int DW    = 8,
    parameter int MAX_W = 64,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = MAX_W / 2;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : pool_linebuf

`default_nettype wire

// File: rtl/maxpool2x2_seq.sv
// ============================================================================
//  Module      : maxpool2x2_seq
//  Description : Streaming 2x2 max-pooling over a raster-order frame of
//                cfg_w x cfg_h unsigned pixels. Even rows are reduced
//                horizontally into a line buffer; odd rows are reduced
//                horizontally and combined with the buffered value to give
//                one pooled pixel per 2x2 block.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                start, cfg_w, cfg_h - frame start request and geometry
//                m_data, m_valid   - input pixel stream (no backpressure)
//                s_data, s_valid   - pooled output, 1-cycle pulse each
//                busy, done, err   - frame status / completion / reject
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool2x2_seq
    import maxpool2x2_seq_pkg::*;
#(
    parameter int DW    = 8,
    parameter int MAX_W = 64,
    parameter int CW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] cfg_w,
    input  logic [CW-1:0] cfg_h,
    input  logic [DW-1:0] m_data,
    input  logic          m_valid,
    output logic [DW-1:0] s_data,
    output logic          s_valid,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int AW = lb_addr_w(MAX_W);

    pool_state_e   state_q;
    logic [CW-1:0] cfg_w_q;
    logic [CW-1:0] cfg_h_q;
    logic [CW-1:0] col_q;
    logic [CW-1:0] row_q;
    logic [DW-1:0] hold_q;
    logic [DW-1:0] s_data_q;
    logic          s_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic          cfg_ok_d;
    logic          col_last_d;
    logic          row_last_d;
    logic [AW-1:0] lb_addr_d;
    logic          lb_we_d;
    logic [DW-1:0] lb_rdata_d;
    logic [DW-1:0] hmax_d;
    logic [DW-1:0] pool_d;

    // Width is compared in int so MAX_W never truncates to CW bits.
    assign cfg_ok_d = !cfg_w[0] && !cfg_h[0] &&
                      (cfg_w != '0) && (cfg_h != '0) &&
                      (int'(cfg_w) <= MAX_W);

    assign col_last_d = (col_q == cfg_w_q - CW'(1));
    assign row_last_d = (row_q == cfg_h_q - CW'(2));

    // Both rows of a block address the same entry: the pixel-pair index.
    assign lb_addr_d = AW'(col_q >> 1);
    assign lb_we_d   = (state_q == ST_ROW_A) && m_valid && col_q[0];

    pool_cmp #(.DW(DW)) u_cmp_h (
        .a_i   (hold_q),
        .b_i   (m_data),
        .max_o (hmax_d)
    );

    pool_cmp #(.DW(DW)) u_cmp_v (
        .a_i   (hmax_d),
        .b_i   (lb_rdata_d),
        .max_o (pool_d)
    );

    pool_linebuf #(
        .DW    (DW),
        .MAX_W (MAX_W),
        .AW    (AW)
    ) u_linebuf (
        .clk     (clk),
        .we_i    (lb_we_d),
        .waddr_i (lb_addr_d),
        .wdata_i (hmax_d),
        .raddr_i (lb_addr_d),
        .rdata_o (lb_rdata_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cfg_w_q   <= '0;
            cfg_h_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            hold_q    <= '0;
            s_data_q  <= '0;
            s_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            s_valid_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_ok_d) begin
                            cfg_w_q <= cfg_w;
                            cfg_h_q <= cfg_h;
                            col_q   <= '0;
                            row_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_ROW_A;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end
                end

                ST_ROW_A, ST_ROW_B: begin
                    if (m_valid) begin
                        if (!col_q[0]) begin
                            hold_q <= m_data;
                        end else if (state_q == ST_ROW_B) begin
                            s_data_q  <= pool_d;
                            s_valid_q <= 1'b1;
                        end

                        // cfg_w is even, so the last column is always odd.
                        if (col_last_d) begin
                            col_q <= '0;
                            if (state_q == ST_ROW_A) begin
                                state_q <= ST_ROW_B;
                            end else if (row_last_d) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                row_q   <= row_q + CW'(2);
                                state_q <= ST_ROW_A;
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end

                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_data  = s_data_q;
    assign s_valid = s_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule : maxpool2x2_seq

`default_nettype wire

// File: tb/tb_maxpool2x2_seq.sv
// ============================================================================
//  Module      : tb_maxpool2x2_seq
//  Description : Self-checking bench for maxpool2x2_seq. Expected pooled
//                values are computed from the driven frame and queued; the
//                negedge monitor pops and compares on every s_valid, and
//                checks s_valid/done/err pulse timing against flags raised
//                by the driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maxpool2x2_seq;

    localparam int DW    = 8;
    localparam int MAX_W = 64;
    localparam int CW    = 7;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] cfg_w;
    logic [CW-1:0] cfg_h;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          busy;
    logic          done;
    logic          err;

    // Driver-side expectations for the cycle being driven.
    logic drv_out;
    logic drv_last;
    logic drv_err;
    logic pend_out;
    logic pend_done;
    logic pend_err;

    int unsigned    n_cmp;
    int unsigned    n_bad;
    int unsigned    n_out;
    logic [DW-1:0]  sb_q [$];
    logic [DW-1:0]  pix  [256];

    maxpool2x2_seq #(
        .DW    (DW),
        .MAX_W (MAX_W),
        .CW    (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cfg_w   (cfg_w),
        .cfg_h   (cfg_h),
        .m_data  (m_data),
        .m_valid (m_valid),
        .s_data  (s_data),
        .s_valid (s_valid),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every output pulse must have been predicted.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_out  = 1'b0;
            pend_done = 1'b0;
            pend_err  = 1'b0;
        end else begin
            check_eq("s_valid", 32'(s_valid), 32'(pend_out));
            check_eq("done",    32'(done),    32'(pend_done));
            check_eq("err",     32'(err),     32'(pend_err));
            if (s_valid) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check_eq("sb_nonempty", 32'(sb_q.size()), 32'd1);
                end else begin
                    check_eq("s_data", 32'(s_data), 32'(sb_q.pop_front()));
                end
            end
            pend_out  = m_valid & drv_out;
            pend_done = m_valid & drv_last;
            pend_err  = start & drv_err;
        end
    end

    task automatic do_start(input int w, input int h, input logic ok);
        start   = 1'b1;
        cfg_w   = CW'(w);
        cfg_h   = CW'(h);
        drv_err = ~ok;
        tick();
        start   = 1'b0;
        drv_err = 1'b0;
        check_eq(ok ? "busy_after_start" : "busy_after_reject",
                 32'(busy), ok ? 32'd1 : 32'd0);
    endtask

    // Drives one frame from pix[], optionally with random gaps and a
    // stray start request part-way through.
    task automatic run_frame(input int w, input int h, input int gap_max,
                             input logic mid_start);
        int out0;
        for (int r = 0; r < h; r += 2) begin
            for (int c = 0; c < w; c += 2) begin
                sb_q.push_back(max2(max2(pix[r*w+c],     pix[r*w+c+1]),
                                    max2(pix[(r+1)*w+c], pix[(r+1)*w+c+1])));
            end
        end
        out0 = int'(n_out);
        do_start(w, h, 1'b1);
        for (int i = 0; i < w*h; i++) begin
            m_data   = pix[i];
            m_valid  = 1'b1;
            drv_out  = ((i / w) % 2 == 1) && ((i % w) % 2 == 1);
            drv_last = (i == w*h - 1);
            if (mid_start && i == 5) begin
                start = 1'b1;
                cfg_w = CW'(2);
                cfg_h = CW'(2);
            end
            tick();
            start    = 1'b0;
            m_valid  = 1'b0;
            drv_out  = 1'b0;
            drv_last = 1'b0;
            if (gap_max > 0 && i != w*h - 1) begin
                repeat ($urandom_range(1, gap_max)) tick();
            end
        end
        @(negedge clk);
        #1;
        check_eq("frame_out_count", 32'(int'(n_out) - out0), 32'((w/2)*(h/2)));
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        tick();
        check_eq("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; n_out = 0;
        rst_n = 1'b0; start = 1'b0; cfg_w = '0; cfg_h = '0;
        m_data = '0; m_valid = 1'b0;
        drv_out = 1'b0; drv_last = 1'b0; drv_err = 1'b0;
        pend_out = 1'b0; pend_done = 1'b0; pend_err = 1'b0;
        repeat (3) tick();
        check_eq("rst_s_valid", 32'(s_valid), 32'd0);
        check_eq("rst_s_data",  32'(s_data),  32'd0);
        check_eq("rst_busy",    32'(busy),    32'd0);
        check_eq("rst_done",    32'(done),    32'd0);
        check_eq("rst_err",     32'(err),     32'd0);
        rst_n = 1'b1;
        tick();

        // Small 4x2 frame, continuous then gapped.
        pix[0] = 8'd1; pix[1] = 8'd5; pix[2] = 8'd2; pix[3] = 8'd7;
        pix[4] = 8'd3; pix[5] = 8'd4; pix[6] = 8'd9; pix[7] = 8'd0;
        run_frame(4, 2, 0, 1'b0);
        check_eq("hold_s_data", 32'(s_data), 32'd9);
        run_frame(4, 2, 3, 1'b0);

        // Rejected geometries.
        do_start(3, 2, 1'b0);
        tick();
        do_start(4, 0, 1'b0);
        tick();
        do_start(MAX_W + 2, 2, 1'b0);
        tick();
        tick();
        check_eq("busy_idle_after_rejects", 32'(busy), 32'd0);

        // Stray start during a frame.
        for (int i = 0; i < 16; i++) pix[i] = DW'($urandom_range(0, 255));
        run_frame(4, 4, 0, 1'b1);

        // Reset after 5 pixels of a 4x4 frame.
        do_start(4, 4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            m_data  = DW'(i * 17 + 3);
            m_valid = 1'b1;
            tick();
            m_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy",    32'(busy),    32'd0);
        check_eq("midrst_s_valid", 32'(s_valid), 32'd0);
        check_eq("midrst_s_data",  32'(s_data),  32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pix[0] = 8'd255; pix[1] = 8'd0; pix[2] = 8'd0; pix[3] = 8'd254;
        run_frame(2, 2, 0, 1'b0);

        // Full-width frames back to back with random data.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 256; i++) pix[i] = DW'($urandom_range(0, 255));
            run_frame(64, 4, 0, 1'b0);
        end

        repeat (3) tick();
        check_eq("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_maxpool2x2_seq

`default_nettype wire

// File: doc/maxpool2x2_seq.md
MAXPOOL2X2_SEQ -- requirements
Module: maxpool2x2_seq

Interface
REQ-001 Parameter DW, default 8: pixel data width, unsigned.
REQ-002 Parameter MAX_W, default 64: maximum frame width in pixels; even.
REQ-003 Parameter CW, default 7: width of cfg_w and cfg_h.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  one-cycle frame start request; cfg_w/cfg_h sampled on the same cycle.
REQ-007 cfg_w  in  CW  frame width in pixels.
REQ-008 cfg_h  in  CW  frame height in rows.
REQ-009 m_data  in  DW  input pixel, raster order.
REQ-010 m_valid  in  1  m_data valid; no backpressure.
REQ-011 s_data  out  DW  pooled 2x2 maximum.
REQ-012 s_valid  out  1  s_data valid, one-cycle pulse per pooled pixel.
REQ-013 busy  out  1  high from accepted start until done.
REQ-014 done  out  1  one-cycle pulse on frame completion.
REQ-015 err  out  1  one-cycle pulse on rejected start.

Function
REQ-016 FSM states: IDLE, ROW_A (even row), ROW_B (odd row), DONE.
REQ-017 IDLE: start with valid cfg -> latch cfg, clear col/row counters, go ROW_A, busy=1 next cycle.
REQ-018 Valid cfg: cfg_w and cfg_h even, nonzero, cfg_w <= MAX_W; otherwise err=1 next cycle, stay IDLE.
REQ-019 start outside IDLE ignored, no err; m_valid in IDLE or DONE ignored.
REQ-020 Column counter advances only on m_valid; cycles with m_valid=0 hold all state (gaps allowed anywhere).
REQ-021 Even column: pixel latched into hold register.
REQ-022 Odd column: hmax = unsigned max(hold, m_data).
REQ-023 ROW_A, odd column: hmax written to line buffer at address col/2.
REQ-024 ROW_B, odd column: s_data <= max(hmax, linebuf[col/2]), s_valid <= 1, registered; latency 1 cycle from accepting the odd-column pixel.
REQ-025 Equal operands: either value (identical) output; comparison strictly unsigned over DW bits.
REQ-026 Last column of row (col = cfg_w-1 accepted): col wraps to 0; ROW_A -> ROW_B; ROW_B -> ROW_A with row += 2.
REQ-027 Last pixel of frame (row = cfg_h-2, ROW_B, col = cfg_w-1): go DONE; done and the final s_valid pulse in the same cycle.
REQ-028 DONE lasts one cycle, busy=0 on exit; -> IDLE; start accepted on the cycle after done.
REQ-029 Outputs per frame: exactly (cfg_w/2)*(cfg_h/2) s_valid pulses.
REQ-030 s_data holds its last value when s_valid=0.

Reset
REQ-031 rst_n low: FSM -> IDLE; counters, hold register, latched cfg, s_data -> 0; s_valid, busy, done, err -> 0.
REQ-032 Reset mid-frame aborts the frame; no done, no further s_valid; line buffer contents not reset and never read before rewritten.

Structure
REQ-033 FSM state encoding and a clog2-based address-width constant live in the shared pool definitions header used by the POOL blocks.
REQ-034 Line buffer is sub-module pool_linebuf: MAX_W/2 x DW, one write and one read port, combinational read, no reset.
REQ-035 Max operations reuse the existing combinational cmp block (DW parameterised), two instances.

Verification
REQ-036 cfg 4x2, pixels 1,5,2,7 / 3,4,9,0 continuous -> s_data 5 then 9, done with second s_valid.
REQ-037 Same frame with m_valid=0 gaps of 1-3 cycles between every pixel -> identical outputs, 1-cycle latency each.
REQ-038 cfg_w=3, or cfg_h=0, or cfg_w=MAX_W+2 -> err pulse, busy stays 0, no s_valid.
REQ-039 start pulsed mid-frame -> ignored, frame completes normally, no err.
REQ-040 rst_n low after 5 pixels of 4x4 frame, then new 2x2 frame 255,0/0,254 -> single s_data 255, done.
REQ-041 Back-to-back 64x4 frames of random data (start on cycle after done) -> 32x2 outputs each matching reference model.
